// File: rtl/ob_pkg.sv
// Shared order-book types: command record, uid, opcode set and default conditional-table depth.
package ob_pkg;

    localparam int CN_N  = 4;
    localparam int UID_W = 8;

    typedef logic [UID_W-1:0] uid_t;

    typedef enum logic [1:0] {
        OP_MARKET   = 2'd0,
        OP_LIMIT    = 2'd1,
        OP_STOP_MKT = 2'd2,
        OP_STOP_LMT = 2'd3
    } opcode_t;

    typedef struct packed {
        opcode_t     op;
        logic        side;
        logic [15:0] price;
        logic [15:0] qty;
        uid_t        uid;
    } cmd_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } issue_state_t;

endpackage

// File: rtl/ob_cn_rr_arb.sv
// Combinational round-robin arbiter: first request after ptr_r (mod N) wins.
module ob_cn_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr_r,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    int               w_idx_i;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk ptr_r+1, ptr_r+2, ... so the last winner becomes lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx_i = 0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx_i = (int'(ptr_r) + k) % N;
            w_idx   = IDX_W'(w_idx_i);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/ob_cn_mtr_issue.sv
// Issues matured conditional-table commands to the order-book core with cancel filtering.
// Optional counters of hand-offs and kills are enabled by OB_CN_MTR_ISSUE_STATS_EN.
module ob_cn_mtr_issue
    import ob_pkg::*;
#(
    parameter int N = CN_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] mtr_vld,
    input  cmd_t         mtr_cmd [N],
    output logic [N-1:0] dl_vld,
    input  logic         cancel,
    input  uid_t         cancel_uid,
    output logic         issue_vld_r,
    output cmd_t         issue_cmd_r,
    input  logic         issue_rdy
`ifdef OB_CN_MTR_ISSUE_STATS_EN
    ,
    output logic [31:0]  stat_issued_r,
    output logic [31:0]  stat_killed_r
`endif
);

    localparam int IDX_W = $clog2(N);

    issue_state_t     r_state;
    issue_state_t     w_state_nxt;
    cmd_t             r_cmd;
    logic [IDX_W-1:0] r_ptr;

    logic             w_full;
    logic             w_kill;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_sel;
    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;

    assign issue_vld_r = (r_state == ST_FULL);
    assign issue_cmd_r = r_cmd;

    assign w_full      = (r_state == ST_FULL);
    assign w_kill      = cancel & w_full & (r_cmd.uid == cancel_uid);
    assign w_accept    = w_full & issue_rdy & ~w_kill;
    assign w_slot_free = ~w_full | w_accept;

    // An entry being cancelled this cycle deallocates itself, so it must not be granted here.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = mtr_vld[i] & ~(cancel & (mtr_cmd[i].uid == cancel_uid));
        end
    end

    ob_cn_rr_arb #(
        .N(N)
    ) u_arb (
        .req     (w_elig),
        .ptr_r   (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_sel  = w_slot_free & (|w_elig) & ~rst;
    assign dl_vld = w_sel ? w_gnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (w_sel) begin
            w_state_nxt = ST_FULL;
        end else if (w_kill || w_accept) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
            r_ptr <= IDX_W'(N - 1);
        end else if (w_sel) begin
            r_cmd <= mtr_cmd[w_gnt_idx];
            r_ptr <= w_gnt_idx;
        end
    end

`ifdef OB_CN_MTR_ISSUE_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_r <= '0;
            stat_killed_r <= '0;
        end else begin
            if (w_accept && (stat_issued_r != 32'hFFFF_FFFF)) begin
                stat_issued_r <= stat_issued_r + 32'd1;
            end
            if (w_kill && (stat_killed_r != 32'hFFFF_FFFF)) begin
                stat_killed_r <= stat_killed_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ob_cn_mtr_issue.sv
// Directed and randomized bench for ob_cn_mtr_issue against an entry-table reference model.
module tb_ob_cn_mtr_issue;
    import ob_pkg::*;

    localparam int N = CN_N;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] mtr_vld;
    cmd_t         mtr_cmd [N];
    logic [N-1:0] dl_vld;
    logic         cancel;
    uid_t         cancel_uid;
    logic         issue_vld_r;
    cmd_t         issue_cmd_r;
    logic         issue_rdy;
`ifdef OB_CN_MTR_ISSUE_STATS_EN
    logic [31:0]  stat_issued_r;
    logic [31:0]  stat_killed_r;
`endif

    ob_cn_mtr_issue #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .mtr_vld     (mtr_vld),
        .mtr_cmd     (mtr_cmd),
        .dl_vld      (dl_vld),
        .cancel      (cancel),
        .cancel_uid  (cancel_uid),
        .issue_vld_r (issue_vld_r),
        .issue_cmd_r (issue_cmd_r),
        .issue_rdy   (issue_rdy)
`ifdef OB_CN_MTR_ISSUE_STATS_EN
        ,
        .stat_issued_r (stat_issued_r),
        .stat_killed_r (stat_killed_r)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: table of matured entries plus a one-deep output slot.
    logic [N-1:0] ent_vld;
    cmd_t         ent_cmd [N];
    bit           keep_ent;
    bit           m_vld;
    cmd_t         m_cmd;
    int           m_ptr;
    longint       m_iss;
    longint       m_kill;
    logic [N-1:0] obs_dl;
    int           n_asrt;
    int           n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input int uid);
        cmd_t c;
        c.op    = opcode_t'($urandom_range(0, 3));
        c.side  = 1'($urandom_range(0, 1));
        c.price = 16'($urandom);
        c.qty   = 16'($urandom);
        c.uid   = uid_t'(uid);
        return c;
    endfunction

    task automatic cycle();
        int           w;
        bit           kill;
        bit           acc;
        bit           free;
        logic [N-1:0] elig;
        logic [N-1:0] exp_dl;
        w      = -1;
        kill   = 1'b0;
        acc    = 1'b0;
        elig   = '0;
        exp_dl = '0;
        for (int i = 0; i < N; i++) begin
            mtr_vld[i] = ent_vld[i];
            mtr_cmd[i] = ent_cmd[i];
        end
        @(negedge clk);
        if (!rst) begin
            kill = cancel && m_vld && (m_cmd.uid == cancel_uid);
            acc  = m_vld && issue_rdy && !kill;
            free = !m_vld || acc;
            for (int i = 0; i < N; i++)
                elig[i] = ent_vld[i] && !(cancel && (ent_cmd[i].uid == cancel_uid));
            if (free) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (w < 0 && elig[j]) w = j;
                end
            end
            if (w >= 0) exp_dl[w] = 1'b1;
        end
        obs_dl = dl_vld;
        chk("dl_vld", dl_vld, exp_dl);
        @(posedge clk);
        #1;
        if (rst) begin
            m_vld  = 1'b0;
            m_cmd  = '0;
            m_ptr  = N - 1;
            m_iss  = 0;
            m_kill = 0;
        end else begin
            if (acc)  m_iss++;
            if (kill) m_kill++;
            if (w >= 0) begin
                m_cmd = ent_cmd[w];
                m_vld = 1'b1;
                m_ptr = w;
            end else if (kill || acc) begin
                m_vld = 1'b0;
            end
            if (!keep_ent) begin
                if (w >= 0) ent_vld[w] = 1'b0;
                for (int i = 0; i < N; i++)
                    if (ent_vld[i] && !elig[i]) ent_vld[i] = 1'b0;
            end
        end
        chk("issue_vld_r", issue_vld_r, m_vld);
        chk("issue_cmd_r", issue_cmd_r, m_cmd);
`ifdef OB_CN_MTR_ISSUE_STATS_EN
        chk("stat_issued_r", stat_issued_r, m_iss[31:0]);
        chk("stat_killed_r", stat_killed_r, m_kill[31:0]);
`endif
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cancel     = 1'b0;
        cancel_uid = '0;
        issue_rdy  = 1'b0;
        keep_ent   = 1'b0;
        ent_vld    = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic put(input int idx, input int uid);
        ent_cmd[idx] = mk_cmd(uid);
        ent_vld[idx] = 1'b1;
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        m_vld  = 1'b0;
        m_cmd  = '0;
        m_ptr  = N - 1;
        m_iss  = 0;
        m_kill = 0;
        for (int i = 0; i < N; i++) ent_cmd[i] = '0;

        // Reset state
        do_reset();
        chk("rst_vld", issue_vld_r, 1'b0);
        chk("rst_cmd", issue_cmd_r, '0);
        chk("rst_dl", obs_dl, '0);

        // Single entry, then pointer check: entry 3 beats entry 1 after granting 2
        issue_rdy = 1'b1;
        put(2, 7);
        cycle();
        chk("single_dl", obs_dl, 4'b0100);
        chk("single_vld", issue_vld_r, 1'b1);
        chk("single_uid", issue_cmd_r.uid, 8'd7);
        put(1, 20);
        put(3, 21);
        cycle();
        chk("ptr_after_2", obs_dl, 4'b1000);
        cycle();
        chk("ptr_next", obs_dl, 4'b0010);

        // Round-robin wrap with entries held matured
        do_reset();
        issue_rdy = 1'b1;
        put(0, 30);
        put(1, 31);
        put(3, 33);
        keep_ent = 1'b1;
        cycle();
        chk("wrap_g0", obs_dl, 4'b0001);
        cycle();
        chk("wrap_g1", obs_dl, 4'b0010);
        chk("wrap_nobubble1", issue_vld_r, 1'b1);
        cycle();
        chk("wrap_g2", obs_dl, 4'b1000);
        chk("wrap_nobubble2", issue_vld_r, 1'b1);
        cycle();
        chk("wrap_g3", obs_dl, 4'b0001);
        chk("wrap_uid", issue_cmd_r.uid, 8'd30);
        keep_ent = 1'b0;

        // Backpressure
        do_reset();
        issue_rdy = 1'b1;
        put(0, 5);
        cycle();
        put(0, 6);
        issue_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_dl", obs_dl, '0);
            chk("bp_hold", issue_cmd_r.uid, 8'd5);
        end
        issue_rdy = 1'b1;
        cycle();
        chk("bp_release_dl", obs_dl, 4'b0001);
        chk("bp_release_uid", issue_cmd_r.uid, 8'd6);

        // Cancel of a pending entry
        do_reset();
        issue_rdy  = 1'b1;
        put(1, 9);
        cancel     = 1'b1;
        cancel_uid = 8'd9;
        cycle();
        chk("cpend_dl", obs_dl, '0);
        chk("cpend_vld", issue_vld_r, 1'b0);
        cancel = 1'b0;

        // Cancel of the output register while the core is ready
        do_reset();
        issue_rdy  = 1'b1;
        put(0, 12);
        cycle();
        cancel     = 1'b1;
        cancel_uid = 8'd12;
        cycle();
        chk("kill_dl", obs_dl, '0);
        chk("kill_vld", issue_vld_r, 1'b0);
        cancel = 1'b0;

        // Mid-operation reset
        do_reset();
        for (int i = 0; i < N; i++) put(i, 40 + i);
        keep_ent  = 1'b1;
        issue_rdy = 1'b0;
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("mrst_dl", obs_dl, '0);
        chk("mrst_vld", issue_vld_r, 1'b0);
        rst = 1'b0;
        cycle();
        chk("mrst_first", obs_dl, 4'b0001);
        keep_ent = 1'b0;

        // Randomized traffic with small uid space so cancels collide often
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++)
                if (!ent_vld[i] && $urandom_range(0, 1) == 0) put(i, int'($urandom_range(0, 15)));
            issue_rdy  = ($urandom_range(0, 3) != 0);
            cancel     = ($urandom_range(0, 3) == 0);
            cancel_uid = uid_t'($urandom_range(0, 15));
            rst        = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst    = 1'b0;
        cancel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/ob_cn_mtr_issue.md
Name: ob_cn_mtr_issue

Overview:
- Downstream of the conditional-table entries. Collects matured Stop orders (already permuted to Market/Limit opcodes) from N entries.
- Each cycle, picks one matured entry round-robin and deallocates it through a one-hot dl_vld.
- Latches the picked command into a single output register and presents it to the order-book core through a valid/ready handshake.
- Filters cancels so a cancelled command is never issued.

Parameters:
- N, 4, number of conditional-table entries served (N >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mtr_vld  in  N  per-entry matured flag (entry busy and matured).
- mtr_cmd  in  N x ob_pkg::cmd_t  per-entry held command (opcode already Market/Limit).
- dl_vld  out  N  one-hot deallocation grant; combinational, same cycle as selection.
- cancel  in  1  cancel request valid.
- cancel_uid  in  ob_pkg::uid_t  uid being cancelled.
- issue_vld_r  out  1  output register holds a command.
- issue_cmd_r  out  ob_pkg::cmd_t  command to order-book core.
- issue_rdy  in  1  core accepts issue_cmd_r this cycle.

Behaviour:
- Reset values: issue_vld_r=0, issue_cmd_r=0, dl_vld=0, round-robin pointer ptr_r=N-1 (so entry 0 is first priority).
- Output FSM has two states, derived from issue_vld_r:
  - EMPTY: issue_vld_r=0.
  - FULL: issue_vld_r=1.
- slot_free = EMPTY | (FULL & issue_rdy & ~kill_out).
- Kill rule: kill_out = cancel & FULL & (issue_cmd_r.uid == cancel_uid). A killed output register goes EMPTY next cycle regardless of issue_rdy. Accept and kill in the same cycle: kill wins, nothing is handed off.
- Eligibility: elig[i] = mtr_vld[i] & ~(cancel & mtr_cmd[i].uid == cancel_uid). The entry cancels itself, so this block must not grant it.
- Selection:
  - Occurs when slot_free & |elig.
  - Winner is the first set elig bit searching ptr_r+1, ptr_r+2, ... modulo N (wrap from N-1 to 0).
  - dl_vld = onehot(winner) in the same cycle; otherwise dl_vld=0.
- On selection:
  - issue_cmd_r <= mtr_cmd[winner]; issue_vld_r <= 1; ptr_r <= winner.
  - The entry returns to IDLE next cycle, so it is never granted twice.
- No selection but slot_free and the register was FULL: issue_vld_r <= 0 (plain drain or kill).
- Latency: an entry maturing in cycle t (mtr_vld visible at t+1) is granted at t+1 if the slot is free, and issue_vld_r is high at t+2.
- Back-to-back throughput is 1 per cycle while issue_rdy stays high: accept and new selection happen in the same cycle.
- Valid stickiness: while FULL and issue_rdy=0, issue_vld_r and issue_cmd_r hold. The only exception is a kill.
- ptr_r updates only on a grant.
- Error path: an entry whose opcode is still a Stop opcode is granted normally.

Optional Feature:
- Macro: OB_CN_MTR_ISSUE_STATS_EN.
- Defined:
  - Adds output stat_issued_r (32 bits), counting accepted hand-offs (issue_vld_r & issue_rdy & ~kill_out).
  - Adds output stat_killed_r (32 bits), counting kills of the output register.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: neither port exists, and the block behaves identically otherwise.

Decomposition:
- In ob_pkg: cmd_t, uid_t, the opcode enum and constant CN_N (= N default).
- Sub-module ob_cn_rr_arb: parameter N; inputs req[N], ptr_r; outputs gnt one-hot plus gnt_idx. Purely combinational rotate/priority/unrotate; reusable by other table arbiters.
- FSM, cancel filter, output register and stats stay in ob_cn_mtr_issue.

Test Plan:
- Single entry: reset, mtr_vld=4'b0100 with uid=7 for 1 cycle, issue_rdy=1 -> dl_vld=4'b0100 the same cycle; issue_vld_r=1 with uid 7 the next cycle; ptr_r=2.
- Round-robin wrap: mtr_vld=4'b1011 held (entries re-mature via model), issue_rdy=1 -> grant order 0,1,3,0; one issue per cycle; no bubble.
- Backpressure: issue_rdy=0 for 5 cycles with the register FULL and mtr_vld=4'b0001 -> dl_vld=0 throughout, output held stable; issue_rdy=1 -> entry 0 granted in that same cycle.
- Cancel of a pending entry: mtr_vld=4'b0010, uid=9, cancel=1 with cancel_uid=9, slot free -> dl_vld=0; register stays EMPTY.
- Cancel of the output register: FULL with uid=12, issue_rdy=1, cancel_uid=12 -> not counted as accepted; issue_vld_r=0 next cycle unless another entry is eligible.
- Mid-operation reset: rst=1 while FULL and mtr_vld=4'b1111 -> next cycle issue_vld_r=0, dl_vld=0 while rst is high; after release, the first grant goes to entry 0.
